instr_fetch_sequencer: RTL and testbench

//  Upstream control stage for the 16-bit FunSel registers: fetches one 16-bit instruction from byte-wide memory.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_timeout_counter.sv | 39 +++
 rtl/instr_fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch sequencer: the FSM state
//   encoding and the FunSel codes of the 16-bit FunSel register family.
//   Optional feature macro used by the importing files: FETCH_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_LO = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_DONE   = 2'd3
    } fetch_state_e;

    localparam logic [2:0] FS_DEC     = 3'b000;
    localparam logic [2:0] FS_INC     = 3'b001;
    localparam logic [2:0] FS_LOAD    = 3'b010;
    localparam logic [2:0] FS_CLR     = 3'b011;
    localparam logic [2:0] FS_LOAD_ZX = 3'b100;
    localparam logic [2:0] FS_LOAD_LO = 3'b101;
    localparam logic [2:0] FS_LOAD_HI = 3'b110;
    localparam logic [2:0] FS_LOAD_SX = 3'b111;

endpackage

// File: rtl/fetch_timeout_counter.sv
// ----------------------------------------------------------------------------
// fetch_timeout_counter
//   Counts memory wait cycles and flags expiry when the count reaches
//   TMO_CYC. Only instantiated when FETCH_TIMEOUT_EN is defined.
// Ports
//   i_clk     rising-edge clock
//   i_rst_n   synchronous active-low reset, clears the count
//   i_clear   clear the count (takes priority over i_count)
//   i_count   advance the count by one
//   o_expire  count == TMO_CYC
// ----------------------------------------------------------------------------
module fetch_timeout_counter #(
    parameter int TMO_CYC = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    localparam int CNT_W = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_expire = (r_cnt == CNT_W'(TMO_CYC));

    // Holds at the limit; the sequencer leaves the wait state on expiry,
    // which clears the count on the following cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_count && !o_expire)
            r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// instr_fetch_sequencer
//   Fetches one 16-bit instruction from byte-wide memory: reads the byte at
//   PC, then at PC+1, loading the IR one byte at a time and incrementing PC
//   after each byte. Started by the control unit, reports Done.
//   Optional feature: FETCH_TIMEOUT_EN adds a MemReady wait limit (TMO_CYC)
//   that aborts the fetch with a one-cycle Error pulse.
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_start      request one fetch (sampled only in IDLE)
//   i_pc         current PC register value
//   i_mem_data   memory read data, valid with i_mem_ready
//   i_mem_ready  memory has data for o_mem_addr
//   o_mem_read   read request (REQ_LO / REQ_HI)
//   o_mem_addr   PC while reading, else 0
//   o_iri        IR data input {8'h00, mem data}
//   o_ire        IR enable
//   o_ir_funsel  IR function select (load low / load high byte)
//   o_pce        PC enable
//   o_pc_funsel  PC function select (always increment)
//   o_busy       state != IDLE
//   o_done       one-cycle fetch-complete pulse
//   o_error      one-cycle timeout abort pulse (0 without FETCH_TIMEOUT_EN)
// ----------------------------------------------------------------------------
module instr_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int HI_FIRST = 0,
    parameter int TMO_CYC  = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [7:0]        i_mem_data,
    input  logic              i_mem_ready,
    output logic              o_mem_read,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_iri,
    output logic              o_ire,
    output logic [2:0]        o_ir_funsel,
    output logic              o_pce,
    output logic [2:0]        o_pc_funsel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    // First byte fetched goes to the low half unless HI_FIRST swaps them.
    localparam logic [2:0] FS_FIRST  = (HI_FIRST != 0) ? FS_LOAD_HI : FS_LOAD_LO;
    localparam logic [2:0] FS_SECOND = (HI_FIRST != 0) ? FS_LOAD_LO : FS_LOAD_HI;

    fetch_state_e r_state;

    logic w_in_req;
    logic w_strobe;
    logic w_expire;
    logic w_timeout;

    assign w_in_req  = (r_state == ST_REQ_LO) || (r_state == ST_REQ_HI);
    assign w_strobe  = w_in_req && i_mem_ready;
    // A byte arriving in the expiry cycle still wins over the abort.
    assign w_timeout = w_in_req && !i_mem_ready && w_expire;

`ifdef FETCH_TIMEOUT_EN
    logic w_tmo_clear;
    logic w_tmo_count;

    // Clearing whenever outside a request state makes every REQ_LO/REQ_HI
    // entry start from zero; a delivered byte also restarts the count.
    assign w_tmo_clear = !w_in_req || i_mem_ready;
    assign w_tmo_count = w_in_req && !i_mem_ready;

    fetch_timeout_counter #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_tmo_clear),
        .i_count  (w_tmo_count),
        .o_expire (w_expire)
    );
`else
    // No wait limit: waits on MemReady indefinitely, TMO_CYC has no effect.
    assign w_expire = 1'b0 & (TMO_CYC != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (i_start) r_state <= ST_REQ_LO;
                ST_REQ_LO: begin
                    if (i_mem_ready)    r_state <= ST_REQ_HI;
                    else if (w_timeout) r_state <= ST_IDLE;
                end
                ST_REQ_HI: begin
                    if (i_mem_ready)    r_state <= ST_DONE;
                    else if (w_timeout) r_state <= ST_IDLE;
                end
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Mealy strobes: IR load and PC increment land on the same edge as the
    // state change, so the REQ_HI address is already PC+1.
    always_comb begin
        o_mem_read  = w_in_req;
        o_mem_addr  = w_in_req ? i_pc : '0;
        o_iri       = w_in_req ? {8'h00, i_mem_data} : 16'h0000;
        o_ire       = w_strobe;
        o_pce       = w_strobe;
        o_pc_funsel = FS_INC;
        o_ir_funsel = 3'b000;
        if (w_strobe)
            o_ir_funsel = (r_state == ST_REQ_LO) ? FS_FIRST : FS_SECOND;
        o_busy      = (r_state != ST_IDLE);
        o_done      = (r_state == ST_DONE);
        o_error     = w_timeout;
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ready;
    logic        start_a, start_b;
    logic        ld;
    logic [15:0] ld_val;

    logic [7:0]  mem [0:65535];

    // DUT A: HI_FIRST=0, DUT B: HI_FIRST=1
    logic [15:0] pc_a, pc_b, ir_a, ir_b;
    logic        rd_a, rd_b, ire_a, ire_b, pce_a, pce_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [15:0] addr_a, addr_b, iri_a, iri_b;
    logic [2:0]  irfs_a, irfs_b, pcfs_a, pcfs_b;
    logic [7:0]  md_a, md_b;

    assign md_a = mem[addr_a];
    assign md_b = mem[addr_b];

    instr_fetch_sequencer #(.ADDR_W(16), .HI_FIRST(0), .TMO_CYC(15)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_pc(pc_a),
        .i_mem_data(md_a), .i_mem_ready(ready),
        .o_mem_read(rd_a), .o_mem_addr(addr_a), .o_iri(iri_a), .o_ire(ire_a),
        .o_ir_funsel(irfs_a), .o_pce(pce_a), .o_pc_funsel(pcfs_a),
        .o_busy(busy_a), .o_done(done_a), .o_error(err_a));

    instr_fetch_sequencer #(.ADDR_W(16), .HI_FIRST(1), .TMO_CYC(15)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_pc(pc_b),
        .i_mem_data(md_b), .i_mem_ready(ready),
        .o_mem_read(rd_b), .o_mem_addr(addr_b), .o_iri(iri_b), .o_ire(ire_b),
        .o_ir_funsel(irfs_b), .o_pce(pce_b), .o_pc_funsel(pcfs_b),
        .o_busy(busy_b), .o_done(done_b), .o_error(err_b));

    // FunSel register models (PC and IR for each DUT)
    always_ff @(posedge clk) begin
        if (ld) begin
            pc_a <= ld_val; pc_b <= ld_val; ir_a <= 16'h0000; ir_b <= 16'h0000;
        end else begin
            if (pce_a && pcfs_a == 3'b001) pc_a <= pc_a + 16'd1;
            if (pce_b && pcfs_b == 3'b001) pc_b <= pc_b + 16'd1;
            if (ire_a && irfs_a == 3'b101) ir_a[7:0]  <= iri_a[7:0];
            if (ire_a && irfs_a == 3'b110) ir_a[15:8] <= iri_a[7:0];
            if (ire_b && irfs_b == 3'b101) ir_b[7:0]  <= iri_b[7:0];
            if (ire_b && irfs_b == 3'b110) ir_b[15:8] <= iri_b[7:0];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_pc(input logic [15:0] v);
        @(negedge clk); ld = 1'b1; ld_val = v;
        @(negedge clk); ld = 1'b0;
    endtask

    // One fetch; MemReady low for lo_wait cycles in REQ_LO and hi_wait in
    // REQ_HI. Returns the cycle (after the Start edge) that Done was seen.
    task automatic run_fetch(input bit sel, input int lo_wait, input int hi_wait,
                             output int done_cyc);
        int c;
        done_cyc = -1;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        ready = 1'b1;
        c = 0;
        while (c < 60 && done_cyc < 0) begin
            @(negedge clk);
            c++;
            start_a = 1'b0; start_b = 1'b0;
            if (c <= lo_wait)                    ready = 1'b0;
            else if (c == lo_wait + 1)           ready = 1'b1;
            else if (c <= lo_wait + 1 + hi_wait) ready = 1'b0;
            else                                 ready = 1'b1;
            #1;
            if (!ready)
                chk("no_strobe_while_wait", sel ? {ire_b, pce_b} : {ire_a, pce_a}, 0);
            if (sel ? done_b : done_a) done_cyc = c;
        end
        ready = 1'b1;
    endtask

    int d;

    initial begin
        rst_n = 1'b0; ready = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ld = 1'b0; ld_val = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",    busy_a, 0);
        chk("rst_done",    done_a, 0);
        chk("rst_memread", rd_a, 0);
        chk("rst_addr",    addr_a, 0);
        chk("rst_strobes", {ire_a, pce_a, irfs_a}, 0);
        chk("rst_pcfs",    pcfs_a, 3'b001);
        chk("rst_err_iri", {err_a, iri_a}, 0);
        rst_n = 1'b1;

        // 1: basic fetch, low byte first
        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        load_pc(16'h0010);
        run_fetch(1'b0, 0, 0, d);
        chk("t1_done_cyc", d, 3);
        chk("t1_ir", ir_a, 16'h1234);
        chk("t1_pc", pc_a, 16'h0012);

        // 2: HI_FIRST=1
        load_pc(16'h0010);
        run_fetch(1'b1, 0, 0, d);
        chk("t2_done_cyc", d, 3);
        chk("t2_ir", ir_b, 16'h3412);
        chk("t2_pc", pc_b, 16'h0012);

        // 3: wait states 3 in REQ_LO, 2 in REQ_HI
        load_pc(16'h0010);
        run_fetch(1'b0, 3, 2, d);
        chk("t3_done_cyc", d, 8);
        chk("t3_ir", ir_a, 16'h1234);
        chk("t3_pc", pc_a, 16'h0012);

        // 4: PC wrap
        mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
        load_pc(16'hFFFF);
        run_fetch(1'b0, 0, 0, d);
        chk("t4_done_cyc", d, 3);
        chk("t4_ir", ir_a, 16'hABCD);
        chk("t4_pc", pc_a, 16'h0001);

        // 5a: reset while in REQ_HI
        load_pc(16'h0010);
        @(negedge clk); start_a = 1'b1; ready = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); #1;
        chk("t5_hi_addr", addr_a, 16'h0011);
        chk("t5_hi_busy", busy_a, 1);
        rst_n = 1'b0; ready = 1'b0;
        @(negedge clk); #1;
        chk("t5_rst_idle", busy_a, 0);
        chk("t5_rst_nodone", done_a, 0);
        chk("t5_rst_pc", pc_a, 16'h0011);
        chk("t5_rst_ir", ir_a, 16'h0034);
        rst_n = 1'b1; ready = 1'b1;

        // 5b: Start held through the whole fetch -> exactly one fetch
        mem[16'h0020] = 8'h78; mem[16'h0021] = 8'h56;
        load_pc(16'h0020);
        @(negedge clk); start_a = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_held_done", done_a, 1);
        start_a = 1'b0;
        @(negedge clk); #1;
        chk("t5_held_idle", busy_a, 0);
        chk("t5_held_pc", pc_a, 16'h0022);
        chk("t5_held_ir", ir_a, 16'h5678);
        @(negedge clk); #1;
        chk("t5_held_stay", {busy_a, pc_a}, {1'b0, 16'h0022});

`ifdef FETCH_TIMEOUT_EN
        // 6: MemReady stuck low -> Error 15 cycles after REQ_LO entry
        begin
            int ec;
            int c;
            ec = -1;
            load_pc(16'h0030);
            @(negedge clk); start_a = 1'b1; ready = 1'b0;
            c = 0;
            while (c < 40 && ec < 0) begin
                @(negedge clk); c++;
                start_a = 1'b0;
                #1;
                if (err_a) ec = c;
            end
            chk("t6_err_cyc", ec, 16);
            chk("t6_no_done", done_a, 0);
            @(negedge clk); #1;
            chk("t6_idle", {busy_a, err_a}, 0);
            chk("t6_pc", pc_a, 16'h0030);
            ready = 1'b1;
        end
`else
        chk("t6_err_tied0", {err_a, err_b}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
